// File: rtl/sevenseg_pkg.sv
// ============================================================================
// Module : sevenseg_pkg
// Brief  : Shared constants, types and helpers for the seven-segment scanner.
//          Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sevenseg_pkg;

  // All segments dark (active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex nibble to segment pattern; element [n] is the pattern for digit n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Scan slot phase: anode lit, or dead time between digits
  typedef enum logic [0:0] {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_t;

  // Bits needed to index n items; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sevenseg_hex_dec.sv
// ============================================================================
// Module : sevenseg_hex_dec
// Brief  : Combinational hex nibble to active-low seven-segment decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sevenseg_hex_dec (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  import sevenseg_pkg::*;

  // Straight table lookup
  assign seg = HEX_SEG[nib];

endmodule

`default_nettype wire

// File: rtl/sevenseg_scan.sv
// ============================================================================
// Module : sevenseg_scan
// Brief  : Time-multiplexed NUM_DIGITS hex display driver with dead-time
//          blanking between digits, optional leading-zero suppression and
//          registered active-low segment outputs.
// Config : define SEVSEG_BLINK_EN to add per-digit blinking (blink_mask port,
//          BLINK_FRAMES parameter).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sevenseg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int DEAD_CYCLES    = 500,
  parameter int DIG_ACTIVE_LOW = 1
`ifdef SEVSEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES   = 64
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
`ifdef SEVSEG_BLINK_EN
  ,
  input  logic [NUM_DIGITS-1:0]   blink_mask
`endif
);
  import sevenseg_pkg::*;

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int CW = idx_width(CLK_DIV);

  localparam logic [CW-1:0] C_CNT_LAST = CW'(CLK_DIV - 1);
  // Last SHOW count of a slot; the following count starts the dead time
  localparam logic [CW-1:0] C_CNT_DEAD = CW'(CLK_DIV - DEAD_CYCLES - 1);
  localparam logic [IW-1:0] C_IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] C_AN_OFF =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  // Captured display contents
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_dpm;
  logic                    r_blz;

  // Scan timing
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_wrap;

  // Per-digit selection results
  logic [NUM_DIGITS-1:0] w_lz;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic                  w_lz_sel;
  logic [6:0]            w_dec_seg;

  // Next values of the registered outputs
  logic [6:0]            w_seg_nxt;
  logic                  w_dp_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;

  assign w_wrap = (r_cnt == C_CNT_LAST);

  // Capture display contents on load; scan timing is left undisturbed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
      r_dpm   <= '0;
      r_blz   <= 1'b0;
    end else if (load) begin
      r_value <= din;
      r_dpm   <= dp_in;
      r_blz   <= blank_lz;
    end
  end

  // Slot divider and digit index; index steps only at slot wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + IW'(1);
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Leading-zero run: digit i (i>0) is blanked when nibbles i..top are all zero
  assign w_lz[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
    if (gi == NUM_DIGITS - 1) begin : g_top
      assign w_lz[gi] = (r_value[4*gi +: 4] == 4'h0);
    end else begin : g_mid
      assign w_lz[gi] = (r_value[4*gi +: 4] == 4'h0) & w_lz[gi+1];
    end
  end

  // Select nibble, decimal point and blanking flag of the current digit
  always_comb begin
    w_nib    = 4'h0;
    w_dp_sel = 1'b0;
    w_lz_sel = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib       = r_value[4*i +: 4];
        w_dp_sel    = r_dpm[i];
        w_lz_sel    = w_lz[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  sevenseg_hex_dec u_dec (
    .nib (w_nib),
    .seg (w_dec_seg)
  );

`ifdef SEVSEG_BLINK_EN
  localparam int FW = idx_width(BLINK_FRAMES);
  localparam logic [FW-1:0] C_FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [NUM_DIGITS-1:0] r_blink_mask;
  logic [FW-1:0]         r_frame;
  logic                  r_phase;
  logic                  w_blink_sel;

  // Blink mask follows the same load strobe as the display value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_mask <= '0;
    end else if (load) begin
      r_blink_mask <= blink_mask;
    end
  end

  // Count full scan frames and flip the blink phase every BLINK_FRAMES
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame <= '0;
      r_phase <= 1'b0;
    end else if (w_wrap && (r_idx == C_IDX_LAST)) begin
      if (r_frame == C_FRAME_LAST) begin
        r_frame <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_frame <= r_frame + FW'(1);
      end
    end
  end

  assign w_blink_sel = |(r_blink_mask & w_onehot);
`endif

  // Slot state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SHOW;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next output values; dead time forces everything dark
  always_comb begin
    w_state_nxt = r_state;
    w_seg_nxt   = SEG_BLANK;
    w_dp_nxt    = 1'b1;
    w_an_nxt    = C_AN_OFF;

    // Wrap is tested first so DEAD_CYCLES=0 never enters BLANK
    if (w_wrap) begin
      w_state_nxt = SHOW;
    end else if (r_cnt == C_CNT_DEAD) begin
      w_state_nxt = BLANK;
    end

    if (r_state == SHOW) begin
      w_an_nxt  = (DIG_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
      w_seg_nxt = (r_blz && w_lz_sel) ? SEG_BLANK : w_dec_seg;
      w_dp_nxt  = ~w_dp_sel;
`ifdef SEVSEG_BLINK_EN
      if (r_phase && w_blink_sel) begin
        w_seg_nxt = SEG_BLANK;
        w_dp_nxt  = 1'b1;
      end
`endif
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= C_AN_OFF;
    end else begin
      seg <= w_seg_nxt;
      dp  <= w_dp_nxt;
      an  <= w_an_nxt;
    end
  end

endmodule

`default_nettype wire
